// File: rtl/pipe_stage_fifo_if.sv
// pipe_stage_fifo_if: upstream/downstream handshake bundle for pipe_stage_fifo.
interface pipe_stage_fifo_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_bus;
  logic             allow_in;
  logic             out_valid;
  logic [WIDTH-1:0] out_bus;
  logic             out_allow_in;
  logic [CW-1:0]    count;
  logic             has_ex;
  modport slave  (input flush, in_valid, in_bus, out_allow_in,
                  output allow_in, out_valid, out_bus, count, has_ex);
  modport master (output flush, in_valid, in_bus, out_allow_in,
                  input allow_in, out_valid, out_bus, count, has_ex);
endinterface

// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: circular-buffer pipeline stage with flush and exception-presence flag.
module pipe_stage_fifo #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 2,
  parameter int EX_BIT = 0
) (
  input logic             clk,
  input logic             resetn,
  pipe_stage_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q, off;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop, has_ex;
  assign bus.allow_in  = (cnt_q < CW'(DEPTH)) || bus.out_allow_in;
  assign bus.out_valid = cnt_q != '0;
  assign bus.out_bus   = mem_q[rd_q];
  assign bus.count     = cnt_q;
  assign bus.has_ex    = has_ex;
  assign push  = bus.in_valid && bus.allow_in && !bus.flush;
  assign pop   = bus.out_valid && bus.out_allow_in && !bus.flush;
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);
  // A slot is live when its distance past the head is below the count.
  always_comb begin
    has_ex = 1'b0;
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_q;
      if (CW'(off) < cnt_q && mem_q[i][EX_BIT]) has_ex = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (bus.flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= bus.in_bus;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_fifo.sv
// tb_pipe_stage_fifo: directed and random checks of pipe_stage_fifo against a queue scoreboard.
module tb_pipe_stage_fifo;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int EX = 4;
  logic clk = 1'b0;
  logic resetn;
  int total = 0;
  int bad   = 0;
  logic [W-1:0] q[$];
  pipe_stage_fifo_if #(.WIDTH(W), .DEPTH(D)) ifc();
  pipe_stage_fifo #(.WIDTH(W), .DEPTH(D), .EX_BIT(EX)) dut (.clk(clk), .resetn(resetn), .bus(ifc.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset();
    for (int oa = 0; oa < 2; oa++) begin
      ifc.out_allow_in = oa[0];
      #1;
      chk("rst_count", 32'(ifc.count), 0);
      chk("rst_out_valid", 32'(ifc.out_valid), 0);
      chk("rst_has_ex", 32'(ifc.has_ex), 0);
      chk("rst_allow_in", 32'(ifc.allow_in), 1);
    end
  endtask
  task automatic step(input logic iv, input logic [W-1:0] d, input logic oa, input logic fl);
    logic exp_ex, exp_allow, push, pop;
    @(negedge clk);
    ifc.in_valid = iv;
    ifc.in_bus = d;
    ifc.out_allow_in = oa;
    ifc.flush = fl;
    #1;
    exp_ex = 1'b0;
    foreach (q[i]) if (q[i][EX]) exp_ex = 1'b1;
    exp_allow = (q.size() < D) || oa;
    chk("count", 32'(ifc.count), q.size());
    chk("out_valid", 32'(ifc.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("out_bus", 32'(ifc.out_bus), 32'(q[0]));
    chk("allow_in", 32'(ifc.allow_in), 32'(exp_allow));
    chk("has_ex", 32'(ifc.has_ex), 32'(exp_ex));
    push = iv && exp_allow && !fl;
    pop  = (q.size() != 0) && oa && !fl;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
    end
  endtask
  initial begin
    resetn = 1'b0;
    ifc.flush = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_bus = '0;
    ifc.out_allow_in = 1'b0;
    chk_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    // Fill with stalled output, then offer one more that must be refused.
    for (int i = 0; i < D; i++) step(1'b1, W'(16'h000A + i), 1'b0, 1'b0);
    step(1'b1, 16'h0EEE, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < D + 1; i++) step(1'b0, '0, 1'b1, 1'b0);
    // Fill then stream through a full buffer so both pointers wrap.
    for (int i = 0; i < D; i++) step(1'b1, W'(16'h0100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, W'(16'h0200 + i), 1'b1, 1'b0);
    for (int i = 0; i < D + 1; i++) step(1'b0, '0, 1'b1, 1'b0);
    // Exception entry behind a plain one: flag tracks it until it leaves.
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    step(1'b1, W'(16'h0002) | W'(1 << EX), 1'b0, 1'b0);
    step(1'b1, 16'h0003, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    // count=1 carrying an exception; flush beats a simultaneous push.
    step(1'b1, W'(1 << EX), 1'b0, 1'b0);
    step(1'b1, 16'h0BAD, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 16'h0C01, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    // Asynchronous reset between edges with three entries held.
    for (int i = 0; i < 3; i++) step(1'b1, W'(16'h0300 + i) | W'(1 << EX), 1'b0, 1'b0);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    #1 resetn = 1'b0;
    chk_reset();
    q.delete();
    #1 resetn = 1'b1;
    step(1'b1, 16'h0D0D, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    // Random traffic with occasional flush.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 31) == 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_fifo.md
PIPE_STAGE_FIFO -- requirements
Module: pipe_stage_fifo

Interface
REQ-001 Parameter WIDTH, default 64: payload bits per entry; legal range 1..512.
REQ-002 Parameter DEPTH, default 2: entry count; power of two, 2..16.
REQ-003 Parameter EX_BIT, default 0: payload bit index flagging an exception-carrying entry; legal range 0..WIDTH-1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 resetn  input  1  reset, asynchronous and active-low.
REQ-006 flush  input  1  pipeline cancel (wb_ex or ertn_flush); discards all entries.
REQ-007 in_valid  input  1  upstream offers an entry.
REQ-008 in_bus  input  WIDTH  upstream payload.
REQ-009 allow_in  output  1  block accepts an entry this cycle.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_bus  output  WIDTH  head entry payload.
REQ-012 out_allow_in  input  1  downstream accepts the head this cycle.
REQ-013 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-014 has_ex  output  1  any valid entry has payload bit EX_BIT set.

Function
REQ-015 push = in_valid && allow_in && !flush; pop = out_valid && out_allow_in && !flush.
REQ-016 allow_in = (count < DEPTH) || out_allow_in; when full this is a combinational path from out_allow_in.
REQ-017 Storage is a circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits wide; each pointer increments by 1 on its event and wraps from DEPTH-1 to 0.
REQ-018 Latency: an entry pushed in cycle N is visible on out_bus/out_valid in cycle N+1 at the earliest; there is no same-cycle bypass.
REQ-019 out_bus is the entry at rd_ptr; when out_valid=0, out_bus is don't-care but stable (no X required).
REQ-020 count next value: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
REQ-021 Push and pop together when full: both occur, count stays DEPTH, order is preserved.
REQ-022 Push and pop together when count=1: the old head leaves and the new entry becomes the head next cycle.
REQ-023 Pop when empty cannot occur because out_valid=0; in_valid while full with out_allow_in=0 is stalled (allow_in=0) and nothing is written.
REQ-024 flush takes priority over push and pop: next cycle count=0, out_valid=0, has_ex=0, and both pointers are reset to 0.
REQ-025 has_ex is combinational over valid entries only; stale data in invalid slots never asserts it.
REQ-026 The block holds no FSM beyond pointers and count; out_valid = (count != 0).
REQ-027 An entry is never lost or duplicated: the out_bus sequence of popped entries equals the pushed sequence, excluding entries discarded by flush.

Reset
REQ-028 While resetn=0: count=0, out_valid=0, has_ex=0, allow_in=1 (given out_allow_in=0 or 1), and wr_ptr=rd_ptr=0, all immediately and without waiting for clk.
REQ-029 Deassertion of resetn is synchronised externally; the first push is accepted on the first rising edge with resetn=1.
REQ-030 Assertion of reset mid-operation discards all entries exactly like flush; payload storage need not be cleared.

Verification
REQ-031 DEPTH=2, push 0xA then 0xB with out_allow_in=0 -> count=2, allow_in=0; then out_allow_in=1 -> out_bus 0xA, then 0xB, then out_valid=0.
REQ-032 Full with in_valid=1 and out_allow_in=1 held for 10 cycles with incrementing data -> count stays 2, outputs appear in order, pointers wrap.
REQ-033 count=1 with EX_BIT set, flush=1 together with in_valid=1 -> next cycle count=0, has_ex=0, and the pushed entry is absent.
REQ-034 Push entry with EX_BIT=1 -> has_ex=1 from the next cycle until that entry pops, then 0.
REQ-035 DEPTH=4, resetn pulsed low mid-cycle while count=3 -> outputs reach reset values before the next edge; the next push pops first with its own value.
REQ-036 Random push/pop/flush for 10k cycles against a queue model, with DEPTH in {2,8,16} and WIDTH in {1,64,512} -> zero mismatches, and count never exceeds DEPTH.
